press_pulse_filter: RTL
=======================

Name: press_pulse_filter

Overview:
- Downstream conditioning stage for one user input line (key/switch) after the two-flop metastability synchronizer.
- Rejects runs shorter than STABLE_CYCLES.
- Emits a single-cycle pulse per accepted press, a filtered level, and a wrapping press count.
- The pulse is the enable/decrement source for the 4-bit ripple down counter stage.

Parameters:
- STABLE_CYCLES, 3, consecutive identical samples needed to accept a press or a release. Legal range 2..255.
- CNT_W, 8, width of the internal run-length counter. Must satisfy 2^CNT_W > STABLE_CYCLES.
- COUNT_W, 4, width of press_count.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; asserting (0) clears all state immediately.
- in  input  1  synchronized user input; 1 = pressed. Arrives already synchronized to clk.
- pulse  output  1  high for exactly one cycle per accepted press.
- level  output  1  debounced input level.
- press_count  output  COUNT_W  number of accepted presses, modulo 2^COUNT_W.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, pulse=0, level=0, press_count=0.
  - Holds for as long as rst=0. Normal operation resumes on the first rising edge with rst=1.
- All outputs are registered. No combinational path from in to any output.
- FSM states, evaluated at each rising edge with rst=1:
  - IDLE (level=0):
    - in=1 -> ARMING, cnt=1.
    - in=0 -> stay, cnt=0.
  - ARMING (level=0):
    - in=0 -> IDLE, cnt=0 (glitch rejected, no pulse).
    - in=1 and cnt+1 == STABLE_CYCLES -> PRESSED, cnt=0, pulse=1, level=1, press_count+1.
    - in=1 otherwise -> cnt+1.
  - PRESSED (level=1):
    - in=0 -> RELEASING, cnt=1.
    - in=1 -> stay.
  - RELEASING (level=1):
    - in=1 -> PRESSED, cnt=0 (release glitch rejected, no new pulse).
    - in=0 and cnt+1 == STABLE_CYCLES -> IDLE, cnt=0, level=0.
    - in=0 otherwise -> cnt+1.
- Latency:
  - pulse and level rise in the cycle after the rising edge that samples the STABLE_CYCLES-th consecutive in=1.
  - level falls in the cycle after the edge that samples the STABLE_CYCLES-th consecutive in=0.
- pulse defaults to 0 every cycle unless set by the ARMING->PRESSED transition. It is never high two consecutive cycles.
  - Minimum spacing between pulses: 2*STABLE_CYCLES cycles.
- press_count wraps from 2^COUNT_W-1 to 0 with no flag.
- Input held high continuously produces exactly one pulse.
- Input held high across reset deassertion: FSM starts in IDLE and counts a fresh run. One pulse follows after STABLE_CYCLES edges.
- Reset mid-ARMING or mid-RELEASING discards the partial run. No pulse is generated for it.
- Unreachable state encodings -> IDLE on the next edge, with cnt=0 and pulse=0.

Decomposition:
- Shared package input_cond_pkg holds:
  - the 2-bit state encodings: IDLE=0, ARMING=1, PRESSED=2, RELEASING=3;
  - the default STABLE_CYCLES constant.
  - Both are reused by the synchronizer and counter stages.
- One natural sub-module: run_length_counter. It holds cnt with clear/increment controls and a done flag at cnt+1 == STABLE_CYCLES.
- The FSM and output registers stay in press_pulse_filter.

Test Plan:
1. Reset, then in=1 for 5 cycles, 0 for 3, 1 for 3 (STABLE_CYCLES=3) -> one pulse on each accepted press; press_count=2; level follows each run with 3-cycle delay.
2. in=1 for 1 cycle, then 0, then 1 for 2 cycles, then 0 -> no pulse; level stays 0; press_count=0.
3. While level=1, in drops to 0 for 1 cycle and returns to 1 -> level remains 1; no second pulse; press_count unchanged.
4. 17 clean presses (4 high / 4 low each) -> 17 one-cycle pulses; press_count reads 1 after the 17th (wrap at 16).
5. Assert rst=0 mid-ARMING (in=1 for 2 cycles) asynchronously between edges -> outputs clear immediately. Release rst with in still 1 -> pulse occurs 3 edges after release; press_count=1.
6. Hold in=1 for 50 cycles -> exactly one pulse; level=1 throughout after cycle 3.

Source files
------------

// File: rtl/input_cond_pkg.sv
// Shared definitions for the input-conditioning chain (synchronizer, debounce filter, counter).
package input_cond_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    PRESSED   = 2'd2,
    RELEASING = 2'd3
  } cond_state_t;

  localparam int DEFAULT_STABLE_CYCLES = 3;

endpackage

// File: rtl/run_length_counter.sv
// Counts consecutive qualifying samples; done flags that the next sample completes the run.
module run_length_counter #(
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic start,
  input  logic inc,
  output logic done
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_plus1;

  assign cnt_plus1 = {1'b0, cnt} + (CNT_W+1)'(1);
  assign done      = (cnt_plus1 == (CNT_W+1)'(STABLE_CYCLES));

  // Priority clr > start > inc; start loads 1 because the sample that begins a run counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CNT_W'(1);
    end else if (inc) begin
      cnt <= cnt_plus1[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/press_pulse_filter.sv
// Debounce filter for one synchronized key line: filtered level, one-cycle press pulse, press count.
module press_pulse_filter
  import input_cond_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = 8,
  parameter int COUNT_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  output logic               pulse,
  output logic               level,
  output logic [COUNT_W-1:0] press_count
);

  // state_q is the observable FSM state for bound checkers.
  cond_state_t        state_q, state_d;
  logic               pulse_d, level_d;
  logic [COUNT_W-1:0] count_d;
  logic               cnt_clr, cnt_start, cnt_inc, cnt_done;

  run_length_counter #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_run (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .start(cnt_start),
    .inc  (cnt_inc),
    .done (cnt_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pulse       <= 1'b0;
      level       <= 1'b0;
      press_count <= '0;
    end else begin
      state_q     <= state_d;
      pulse       <= pulse_d;
      level       <= level_d;
      press_count <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pulse_d   = 1'b0;
    level_d   = level;
    count_d   = press_count;
    cnt_clr   = 1'b0;
    cnt_start = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        level_d = 1'b0;
        if (in) begin
          state_d   = ARMING;
          cnt_start = 1'b1;
        end else begin
          cnt_clr = 1'b1;
        end
      end
      ARMING: begin
        level_d = 1'b0;
        if (!in) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else if (cnt_done) begin
          state_d = PRESSED;
          cnt_clr = 1'b1;
          pulse_d = 1'b1;
          level_d = 1'b1;
          count_d = press_count + COUNT_W'(1);
        end else begin
          cnt_inc = 1'b1;
        end
      end
      PRESSED: begin
        level_d = 1'b1;
        if (!in) begin
          state_d   = RELEASING;
          cnt_start = 1'b1;
        end
      end
      RELEASING: begin
        level_d = 1'b1;
        if (in) begin
          state_d = PRESSED;
          cnt_clr = 1'b1;
        end else if (cnt_done) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
          level_d = 1'b0;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
        level_d = 1'b0;
      end
    endcase
  end

endmodule
